// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: mode-0 SPI slave giving an external master read/write access to a register bank.
// Define SPI_REG_BRIDGE_BURST_EN to auto-increment the address and keep streaming words until cs_n rises.
module spi_reg_bridge #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [DATA_W-1:0] reg_data_o,
  output logic              reg_data_o_dv,
  output logic              reg_rd_strobe,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
`ifdef SPI_REG_BRIDGE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, HOLD} state_t;
  state_t state;
  logic [2:0] raw, sync;
  logic cs, ck, mo, cs_p, ck_p, rise, fall, rose, inc, fetch;
  logic [CW-1:0] cnt;
  logic [DATA_W-2:0] sh;
  logic [DATA_W-1:0] tx, word;
  assign raw = {spi_cs_n, spi_clk, spi_mosi};
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync = raw;
    end else begin : g_sync
      logic [3*SYNC_STAGES-1:0] pipe;
      always_ff @(posedge clk or posedge rst)
        if (rst) pipe <= '0;
        else pipe <= (pipe << 3) | (3*SYNC_STAGES)'(raw);
      assign sync = pipe[3*SYNC_STAGES-1 -: 3];
    end
  endgenerate
  assign {cs, ck, mo} = sync;
  assign rise = ck & ~ck_p;
  assign fall = ~ck & ck_p;
  assign word = {sh, mo};
  assign busy = state != IDLE;
  assign spi_miso_oe = state == RDATA;
  assign spi_miso = spi_miso_oe & tx[DATA_W-1];
  // rose gates shifting so the fall right after a (re)load never eats the MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cs_p <= 1'b0;
      ck_p <= 1'b0;
      rose <= 1'b0;
      inc <= 1'b0;
      fetch <= 1'b0;
      cnt <= '0;
      sh <= '0;
      tx <= '0;
      reg_addr <= '0;
      reg_data_o <= '0;
      reg_data_o_dv <= 1'b0;
      reg_rd_strobe <= 1'b0;
    end else begin
      cs_p <= cs;
      ck_p <= ck;
      reg_data_o_dv <= 1'b0;
      reg_rd_strobe <= 1'b0;
      if (state != IDLE && (cs || !ena)) begin
        state <= IDLE;
        inc <= 1'b0;
        fetch <= 1'b0;
      end else if (inc) begin
        reg_addr <= reg_addr + ADDR_W'(1);
        inc <= 1'b0;
        fetch <= state == RDATA;
      end else if (fetch) begin
        tx <= reg_data_i;
        reg_rd_strobe <= 1'b1;
        fetch <= 1'b0;
      end else begin
        case (state)
          IDLE: if (ena && cs_p && !cs) begin
            state <= CMD;
            cnt <= '0;
          end
          CMD: if (rise) begin
            sh <= word[DATA_W-2:0];
            cnt <= cnt + CW'(1);
            if (cnt == CW'(ADDR_W)) begin
              reg_addr <= word[ADDR_W-1:0];
              cnt <= '0;
              rose <= 1'b0;
              fetch <= !word[ADDR_W];
              state <= word[ADDR_W] ? WDATA : RDATA;
            end
          end
          WDATA: if (rise) begin
            sh <= word[DATA_W-2:0];
            cnt <= cnt + CW'(1);
            if (cnt == CW'(DATA_W-1)) begin
              reg_data_o <= word;
              reg_data_o_dv <= 1'b1;
              cnt <= '0;
              inc <= BURST;
              state <= BURST ? WDATA : HOLD;
            end
          end
          RDATA: if (rise) begin
            rose <= cnt != CW'(DATA_W-1);
            cnt <= cnt + CW'(1);
            if (cnt == CW'(DATA_W-1)) begin
              cnt <= '0;
              inc <= BURST;
              state <= BURST ? RDATA : HOLD;
            end
          end else if (fall && rose) begin
            tx <= tx << 1;
            rose <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed vector table plus hand-written abort, reset, enable and burst sequences.
module tb_spi_reg_bridge;
  localparam int HALF = 6;
`ifdef SPI_REG_BRIDGE_BURST_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, ena = 1'b1;
  logic spi_cs_n = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, reg_data_o_dv, reg_rd_strobe, busy;
  logic [3:0] reg_addr;
  logic [7:0] reg_data_i = 8'h00, reg_data_o;
  int n_vec = 0, n_bad = 0, dv_cnt = 0, rd_cnt = 0, busy_seen = 0;
  logic [3:0] ev_addr [4];
  logic [7:0] ev_data [4];
  logic [31:0] rx;
  int oec, oed;

  typedef struct {
    logic w; logic [3:0] a; logic [7:0] d; logic [7:0] rd;
    int dv; int rs; logic [3:0] ea; logic [7:0] eo; logic [7:0] erx; int eoe;
  } vec_t;
  vec_t vt [4];

  always #5 clk = ~clk;

  spi_reg_bridge dut (
    .clk(clk), .rst(rst), .ena(ena), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_addr(reg_addr), .reg_data_i(reg_data_i), .reg_data_o(reg_data_o),
    .reg_data_o_dv(reg_data_o_dv), .reg_rd_strobe(reg_rd_strobe), .busy(busy)
  );

  always @(negedge clk) begin
    if (reg_data_o_dv) begin
      if (dv_cnt < 4) begin
        ev_addr[dv_cnt] = reg_addr;
        ev_data[dv_cnt] = reg_data_o;
      end
      dv_cnt++;
    end
    if (reg_rd_strobe) rd_cnt++;
    if (busy) busy_seen++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    dv_cnt = 0; rd_cnt = 0; busy_seen = 0;
    for (int i = 0; i < 4; i++) begin ev_addr[i] = '0; ev_data[i] = '0; end
  endtask

  task automatic xbit(input logic b, output logic m, output logic oe);
    spi_mosi = b;
    ticks(HALF);
    m = spi_miso;
    oe = spi_miso_oe;
    spi_clk = 1'b1;
    ticks(HALF);
    spi_clk = 1'b0;
  endtask

  task automatic send(input logic [31:0] bits, input int n, output logic [31:0] r, output int ones);
    logic m, oe;
    r = '0;
    ones = 0;
    for (int i = n - 1; i >= 0; i--) begin
      xbit(bits[i], m, oe);
      r = {r[30:0], m};
      ones += int'(oe);
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    ticks(HALF);
  endtask

  task automatic cs_high();
    spi_mosi = 1'b0;
    ticks(HALF);
    spi_cs_n = 1'b1;
    ticks(2 * HALF);
  endtask

  task automatic frame(input logic w, input logic [3:0] a, input logic [7:0] d,
                       output logic [31:0] r, output int oe_cmd, output int oe_dat);
    logic [31:0] junk;
    clear_mon();
    cs_low();
    send({27'd0, w, a}, 5, junk, oe_cmd);
    send({24'd0, d}, 8, r, oe_dat);
    cs_high();
  endtask

  initial begin
    vt[0] = '{1'b1, 4'h5, 8'hA5, 8'h00, 1, 0, 4'h5, 8'hA5, 8'h00, 0};
    vt[1] = '{1'b0, 4'h3, 8'h00, 8'h3C, 0, 1, 4'h3, 8'hA5, 8'h3C, 8};
    vt[2] = '{1'b1, 4'hA, 8'h5A, 8'h00, 1, 0, 4'hA, 8'h5A, 8'h00, 0};
    vt[3] = '{1'b0, 4'hF, 8'h00, 8'h81, 0, 1, 4'hF, 8'h5A, 8'h81, 8};

    ticks(3);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_oe", {31'd0, spi_miso_oe}, 0);
    chk("rst_miso", {31'd0, spi_miso}, 0);
    chk("rst_strobes", {30'd0, reg_data_o_dv, reg_rd_strobe}, 0);
    chk("rst_addr", {28'd0, reg_addr}, 0);
    chk("rst_data", {24'd0, reg_data_o}, 0);
    rst = 1'b0;
    ticks(4 * HALF);

    for (int i = 0; i < 4; i++) begin
      reg_data_i = vt[i].rd;
      frame(vt[i].w, vt[i].a, vt[i].d, rx, oec, oed);
      chk($sformatf("v%0d_dv", i), dv_cnt, vt[i].dv);
      chk($sformatf("v%0d_rd", i), rd_cnt, vt[i].rs + (vt[i].w ? 0 : B));
      chk($sformatf("v%0d_addr", i), {28'd0, reg_addr}, {28'd0, 4'(vt[i].ea + B)});
      chk($sformatf("v%0d_data", i), {24'd0, reg_data_o}, {24'd0, vt[i].eo});
      chk($sformatf("v%0d_miso", i), rx, {24'd0, vt[i].erx});
      chk($sformatf("v%0d_oe_cmd", i), oec, 0);
      chk($sformatf("v%0d_oe_data", i), oed, vt[i].eoe);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 0);
      chk($sformatf("v%0d_oe_idle", i), {31'd0, spi_miso_oe}, 0);
      if (vt[i].dv > 0) begin
        chk($sformatf("v%0d_dv_addr", i), {28'd0, ev_addr[0]}, {28'd0, vt[i].a});
        chk($sformatf("v%0d_dv_data", i), {24'd0, ev_data[0]}, {24'd0, vt[i].d});
      end
    end

    clear_mon();
    cs_low();
    send({27'd0, 1'b1, 4'hF}, 5, rx, oec);
    send(32'h11, 8, rx, oed);
    send(32'h22, 8, rx, oed);
    cs_high();
    chk("burst_dv_cnt", dv_cnt, 1 + B);
    chk("burst_ev0_addr", {28'd0, ev_addr[0]}, 32'hF);
    chk("burst_ev0_data", {24'd0, ev_data[0]}, 32'h11);
    chk("burst_ev1_addr", {28'd0, ev_addr[1]}, 32'h0);
    chk("burst_ev1_data", {24'd0, ev_data[1]}, B ? 32'h22 : 32'h00);
    chk("burst_addr_end", {28'd0, reg_addr}, B ? 32'h1 : 32'hF);
    chk("burst_data_end", {24'd0, reg_data_o}, B ? 32'h22 : 32'h11);

    clear_mon();
    cs_low();
    send({27'd0, 1'b1, 4'h2}, 5, rx, oec);
    send(32'h15, 5, rx, oed);
    chk("abort_busy_before", {31'd0, busy}, 1);
    spi_cs_n = 1'b1;
    ticks(3);
    chk("abort_idle", {31'd0, busy}, 0);
    ticks(2 * HALF);
    chk("abort_dv", dv_cnt, 0);
    chk("abort_data", {24'd0, reg_data_o}, B ? 32'h22 : 32'h11);
    chk("abort_addr", {28'd0, reg_addr}, 32'h2);

    clear_mon();
    cs_low();
    send({27'd0, 1'b1, 4'h6}, 5, rx, oec);
    send(32'h1E, 7, rx, oed);
    spi_mosi = 1'b0;
    ticks(HALF);
    spi_clk = 1'b1;
    spi_cs_n = 1'b1;
    ticks(HALF);
    spi_clk = 1'b0;
    ticks(2 * HALF);
    chk("race_dv", dv_cnt, 0);
    chk("race_data", {24'd0, reg_data_o}, B ? 32'h22 : 32'h11);
    chk("race_busy", {31'd0, busy}, 0);

    clear_mon();
    cs_low();
    send(32'h4, 3, rx, oec);
    chk("pre_rst_busy", {31'd0, busy}, 1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_outputs",
        {16'd0, busy, spi_miso_oe, spi_miso, reg_data_o_dv, reg_addr, reg_data_o},
        32'd0);
    chk("mid_rst_strobe", {31'd0, reg_rd_strobe}, 0);
    @(negedge clk);
    rst = 1'b0;
    spi_cs_n = 1'b1;
    ticks(2 * HALF);
    frame(1'b1, 4'h1, 8'h7E, rx, oec, oed);
    chk("post_rst_dv", dv_cnt, 1);
    chk("post_rst_dv_addr", {28'd0, ev_addr[0]}, 32'h1);
    chk("post_rst_dv_data", {24'd0, ev_data[0]}, 32'h7E);

    ena = 1'b0;
    frame(1'b1, 4'h4, 8'h99, rx, oec, oed);
    chk("ena0_w_dv", dv_cnt, 0);
    chk("ena0_w_busy", busy_seen, 0);
    reg_data_i = 8'hC3;
    frame(1'b0, 4'h7, 8'h00, rx, oec, oed);
    chk("ena0_r_strobe", rd_cnt, 0);
    chk("ena0_r_miso", rx, 0);
    chk("ena0_data", {24'd0, reg_data_o}, 32'h7E);
    ena = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
